ufm_stream_seq: RTL and testbench

//  Multi-region UFM byte streamer: walks a selectable address window, fetches bytes through the
//  UFM reader's bus__ interface and hands them to a byte sink (UART tx) with valid/ready.

---
 rtl/ufm_pkg.sv | 25 ++
 rtl/ufm_pause_timer.sv | 34 +++
 rtl/ufm_stream_seq.sv | 176 +++++++++++++++++
 tb/tb_ufm_stream_seq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ufm_pkg.sv
// Shared definitions for the UFM streaming blocks: address geometry, sequencer
// state encoding and an oscillator-frequency to cycle-count helper.
package ufm_pkg;

    localparam int UFM_ADDR_W      = 15;
    localparam int UFM_PAGE_BYTES  = 16;
    localparam int UFM_SPACE_BYTES = 1 << UFM_ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DRAIN = 3'd4
    } seq_state_e;

    // Cycles of a clock at freq_khz spanning period_us microseconds.
    function automatic logic [31:0] osch_cycles(input int unsigned freq_khz,
                                                input int unsigned period_us);
        logic [63:0] prod;
        prod = (64'(freq_khz) * 64'(period_us)) / 64'd1000;
        return prod[31:0];
    endfunction

endpackage

// File: rtl/ufm_pause_timer.sv
// Loadable 32-bit down-counter; expired_o is high while the count sits at zero.
module ufm_pause_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ufm_stream_seq.sv
// Streams bytes from a selectable UFM address window to a valid/ready byte sink,
// one-shot or looping with a timed pause between passes.
//  state | meaning
//  IDLE  | waiting for start
//  FETCH | read request outstanding (rd_en high)
//  SEND  | byte presented to sink
//  PAUSE | idle gap between loop passes
//  DRAIN | abort seen mid-read; swallowing the pending reader byte
module ufm_stream_seq
    import ufm_pkg::*;
#(
    parameter int                         NUM_REGIONS   = 2,
    parameter int                         REGION_W      = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
    parameter logic [15*NUM_REGIONS-1:0]  REGION_STARTS = {15'd32672, 15'd0},
    parameter logic [16*NUM_REGIONS-1:0]  REGION_SIZES  = {16'd64, 16'd16},
    parameter int unsigned                PAUSE_CYCLES  = osch_cycles(24180, 500000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [REGION_W-1:0]   region_sel,
    input  logic                  loop_en,
    output logic [UFM_ADDR_W-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [7:0]            rd_data,
    input  logic                  rd_valid,
    output logic [7:0]            snk_data,
    output logic                  snk_valid,
    input  logic                  snk_ready,
    output logic                  busy,
    output logic                  done
);

    logic [UFM_ADDR_W-1:0] start_tbl [NUM_REGIONS];
    logic [15:0]           size_tbl  [NUM_REGIONS];

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        assign start_tbl[g] = REGION_STARTS[15*g +: 15];
        assign size_tbl[g]  = REGION_SIZES[16*g +: 16];
        if (int'(REGION_STARTS[15*g +: 15]) + int'(REGION_SIZES[16*g +: 16]) > UFM_SPACE_BYTES) begin : g_bad
            $error("ufm_stream_seq: region %0d runs past the end of the UFM address space", g);
        end
    end

    seq_state_e            state_q, state_d;
    logic [UFM_ADDR_W-1:0] base_q, base_d;
    logic [UFM_ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]           size_q, size_d;
    logic [15:0]           remain_q, remain_d;
    logic [7:0]            data_q, data_d;
    logic                  done_q, done_d;
    logic                  tmr_load, tmr_expired;
    logic                  sel_ok;
    logic [REGION_W-1:0]   sel_idx;

    // Out-of-range selects are masked to 0 so the table is never indexed past its end.
    assign sel_ok  = (32'(region_sel) < 32'(NUM_REGIONS));
    assign sel_idx = sel_ok ? region_sel : '0;

    ufm_pause_timer #(.CNT_W(32)) u_pause (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (32'(PAUSE_CYCLES)),
        .en_i       (state_q == ST_PAUSE),
        .expired_o  (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        addr_d   = addr_q;
        size_d   = size_q;
        remain_d = remain_q;
        data_d   = data_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (abort) begin
                    done_d = 1'b1;
                end else if (start && sel_ok) begin
                    base_d   = start_tbl[sel_idx];
                    addr_d   = start_tbl[sel_idx];
                    size_d   = size_tbl[sel_idx];
                    remain_d = size_tbl[sel_idx];
                    if (size_tbl[sel_idx] == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                // A byte landing in the abort cycle completes the read, so no drain is needed.
                if (abort) begin
                    if (rd_valid) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (rd_valid) begin
                    data_d  = rd_data;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (snk_ready) begin
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        addr_d = base_q;
                        if (loop_en) begin
                            remain_d = size_q;
                            tmr_load = 1'b1;
                            state_d  = ST_PAUSE;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_PAUSE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (tmr_expired) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (rd_valid) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            remain_q <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            remain_q <= remain_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    assign rd_addr   = addr_q;
    assign rd_en     = (state_q == ST_FETCH);
    assign snk_data  = data_q;
    assign snk_valid = (state_q == ST_SEND);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_ufm_stream_seq.sv
// Self-checking bench for ufm_stream_seq: reader/sink models, a table of one-shot
// passes, and hand-written sequences for loop, backpressure, abort and reset cases.
module tb_ufm_stream_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, loop_en;
    logic [1:0]  region_sel;
    logic [14:0] rd_addr;
    logic        rd_en;
    logic [7:0]  rd_data = 8'h00;
    logic        rd_valid = 1'b0;
    logic [7:0]  snk_data;
    logic        snk_valid;
    logic        snk_ready = 1'b0;
    logic        busy, done;

    always #5 clk = ~clk;

    ufm_stream_seq #(
        .NUM_REGIONS   (3),
        .REGION_STARTS ({15'd100, 15'd32672, 15'd0}),
        .REGION_SIZES  ({16'd0, 16'd64, 16'd16}),
        .PAUSE_CYCLES  (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .region_sel (region_sel),
        .loop_en    (loop_en),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .snk_data   (snk_data),
        .snk_valid  (snk_valid),
        .snk_ready  (snk_ready),
        .busy       (busy),
        .done       (done)
    );

    // Reference region table and UFM contents.
    localparam int R_START [3] = '{0, 32672, 100};
    localparam int R_SIZE  [3] = '{16, 64, 0};

    function automatic logic [7:0] ufm_byte(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'hA5;
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reader and sink models plus event logging, all evaluated on the falling edge.
    int          rd_lat   = 2;    // negative: random 0..3 per read
    int          rdy_mode = 0;    // 0 always ready, 1 random, 2 stalled
    bit          rd_pending = 0;
    int          rd_cnt = 0;
    logic [14:0] rd_req_addr = '0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          rd_en_cnt = 0;
    int          done_cyc = 0;
    int          last_rdv_cyc = 0;
    logic [7:0]  cap_data [$];
    logic [14:0] cap_addr [$];
    int          cap_cyc  [$];

    always @(negedge clk) begin
        int lat;
        cyc++;
        if (!rst) begin
            rd_valid   = 1'b0;
            rd_pending = 0;
        end else if (rd_valid) begin
            rd_valid = 1'b0;
        end else if (rd_pending) begin
            if (rd_cnt <= 1) begin
                rd_valid     = 1'b1;
                rd_data      = ufm_byte(rd_req_addr);
                rd_pending   = 0;
                last_rdv_cyc = cyc;
            end else begin
                rd_cnt--;
            end
        end else if (rd_en) begin
            rd_req_addr = rd_addr;
            lat = (rd_lat < 0) ? int'($urandom_range(0, 3)) : rd_lat;
            if (lat == 0) begin
                rd_valid     = 1'b1;
                rd_data      = ufm_byte(rd_req_addr);
                last_rdv_cyc = cyc;
            end else begin
                rd_pending = 1;
                rd_cnt     = lat;
            end
        end
        case (rdy_mode)
            0:       snk_ready = 1'b1;
            1:       snk_ready = ($urandom_range(0, 3) != 0);
            default: snk_ready = 1'b0;
        endcase
        if (rst && snk_valid && snk_ready) begin
            cap_data.push_back(snk_data);
            cap_addr.push_back(rd_addr);
            cap_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rd_en) rd_en_cnt++;
    end

    task automatic pulse_start(input logic [1:0] sel);
        start      = 1'b1;
        region_sel = sel;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Compare captured handshakes against the byte sequence the region should produce.
    task automatic check_stream(input string tag, input int c0, input int sel, input int n);
        int avail;
        logic [14:0] ea;
        avail = cap_data.size() - c0;
        for (int k = 0; k < n && k < avail; k++) begin
            ea = 15'(R_START[sel] + (k % R_SIZE[sel]));
            check($sformatf("%s_addr%0d", tag, k), 32'(cap_addr[c0+k]), 32'(ea));
            check($sformatf("%s_data%0d", tag, k), 32'(cap_data[c0+k]), 32'(ufm_byte(ea)));
        end
    endtask

    typedef struct {
        logic [1:0]  sel;
        int          lat;
        int          rmode;
        int          exp_n;
        logic [14:0] exp_base;
    } vec_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [4];
        bit   ok;
        int   c0, d0, e0, bad, gap;

        vecs[0] = '{sel: 2'd0, lat: 2,  rmode: 0, exp_n: 16, exp_base: 15'd0};
        vecs[1] = '{sel: 2'd0, lat: -1, rmode: 1, exp_n: 16, exp_base: 15'd0};
        vecs[2] = '{sel: 2'd1, lat: 3,  rmode: 1, exp_n: 64, exp_base: 15'd32672};
        vecs[3] = '{sel: 2'd1, lat: 0,  rmode: 0, exp_n: 64, exp_base: 15'd32672};

        rst = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0; region_sel = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_snk_data", 32'(snk_data), 0);
        check("rst_snk_valid", 32'(snk_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst = 1'b1;
        @(negedge clk);

        // One-shot passes from the table.
        for (int v = 0; v < 4; v++) begin
            rd_lat   = vecs[v].lat;
            rdy_mode = vecs[v].rmode;
            loop_en  = 1'b0;
            c0 = cap_data.size();
            d0 = done_cnt;
            pulse_start(vecs[v].sel);
            wait_done(3000, ok);
            check($sformatf("v%0d_done_seen", v), 32'(ok), 1);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_count", v), 32'(cap_data.size() - c0), 32'(vecs[v].exp_n));
            check_stream($sformatf("v%0d", v), c0, int'(vecs[v].sel), vecs[v].exp_n);
            check($sformatf("v%0d_done_once", v), 32'(done_cnt - d0), 1);
            check($sformatf("v%0d_rd_addr_home", v), 32'(rd_addr), 32'(vecs[v].exp_base));
            check($sformatf("v%0d_busy", v), 32'(busy), 0);
        end

        // Looping pass over region 1, loop_en cleared partway through pass 2.
        rd_lat = 2; rdy_mode = 0; loop_en = 1'b1;
        c0 = cap_data.size();
        d0 = done_cnt;
        pulse_start(2'd1);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cap_data.size() - c0 >= 74) begin
                ok = 1;
                break;
            end
        end
        check("loop_pass2_reached", 32'(ok), 1);
        loop_en = 1'b0;
        wait_done(3000, ok);
        check("loop_done_seen", 32'(ok), 1);
        repeat (2) @(negedge clk);
        check("loop_count", 32'(cap_data.size() - c0), 128);
        check_stream("loop", c0, 1, 128);
        check("loop_done_once", 32'(done_cnt - d0), 1);
        gap = (cap_cyc.size() >= c0 + 65) ? cap_cyc[c0+64] - cap_cyc[c0+63] : 0;
        check("loop_pause_ge_100", 32'(gap >= 100), 1);

        // Backpressure on byte 3 of region 0.
        rd_lat = 1; rdy_mode = 0;
        c0 = cap_data.size();
        pulse_start(2'd0);
        for (int i = 0; i < 500 && (cap_data.size() - c0 < 3); i++) @(negedge clk);
        rdy_mode = 2;
        for (int i = 0; i < 100 && !snk_valid; i++) @(negedge clk);
        check("bp_valid_up", 32'(snk_valid), 1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!(snk_valid && snk_data == ufm_byte(15'd3) && !rd_en && rd_addr == 15'd3)) bad++;
        end
        check("bp_unstable_cycles", 32'(bad), 0);
        check("bp_count_held", 32'(cap_data.size() - c0), 3);
        rdy_mode = 0;
        wait_done(1000, ok);
        check("bp_done_seen", 32'(ok), 1);
        repeat (2) @(negedge clk);
        check("bp_count", 32'(cap_data.size() - c0), 16);
        check_stream("bp", c0, 0, 16);

        // Abort while a read is outstanding: drain, no byte presented.
        rd_lat = 5; rdy_mode = 0;
        c0 = cap_data.size();
        d0 = done_cnt;
        pulse_start(2'd1);
        for (int i = 0; i < 20 && !rd_en; i++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_rd_en_dropped", 32'(rd_en), 0);
        check("abort_busy_draining", 32'(busy), 1);
        wait_done(50, ok);
        check("abort_done_seen", 32'(ok), 1);
        repeat (2) @(negedge clk);
        check("abort_done_after_rdvalid", 32'(done_cyc - last_rdv_cyc), 1);
        check("abort_no_byte", 32'(cap_data.size() - c0), 0);
        check("abort_done_once", 32'(done_cnt - d0), 1);
        check("abort_idle", 32'(busy), 0);

        // abort and start in the same IDLE cycle.
        d0 = done_cnt;
        e0 = rd_en_cnt;
        abort = 1'b1;
        pulse_start(2'd0);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("abst_busy", 32'(busy), 0);
        check("abst_no_rd_en", 32'(rd_en_cnt - e0), 0);
        check("abst_done", 32'(done_cnt - d0), 1);

        // Asynchronous reset between edges while a byte is presented.
        rd_lat = 1; rdy_mode = 2;
        pulse_start(2'd0);
        for (int i = 0; i < 50 && !snk_valid; i++) @(negedge clk);
        check("arst_pre_valid", 32'(snk_valid), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_snk_valid", 32'(snk_valid), 0);
        check("arst_snk_data", 32'(snk_data), 0);
        check("arst_rd_addr", 32'(rd_addr), 0);
        check("arst_rd_en", 32'(rd_en), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        rdy_mode = 0;
        @(negedge clk);

        // Zero-size region: done only. Out-of-range select: nothing.
        d0 = done_cnt;
        e0 = rd_en_cnt;
        pulse_start(2'd2);
        repeat (3) @(negedge clk);
        check("zero_done", 32'(done_cnt - d0), 1);
        check("zero_no_rd_en", 32'(rd_en_cnt - e0), 0);
        check("zero_busy", 32'(busy), 0);
        d0 = done_cnt;
        pulse_start(2'd3);
        repeat (3) @(negedge clk);
        check("badsel_done", 32'(done_cnt - d0), 0);
        check("badsel_no_rd_en", 32'(rd_en_cnt - e0), 0);
        check("badsel_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
